// File: rtl/single_max_reduce.sv
// Vector max reduction sequencer that time-shares one external pipelined single_max unit.
// Define SINGLE_MAX_REDUCE_INDEX_EN to add out_index (position of the winning element).
module single_max_reduce #(
  parameter int MAX_LATENCY = 2,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [31:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic [31:0]        max_a,
  output logic [31:0]        max_b,
  input  logic [31:0]        max_z
`ifdef SINGLE_MAX_REDUCE_INDEX_EN
  ,
  output logic [COUNT_W-1:0] out_index
`endif
);

  localparam int LAT_W = (MAX_LATENCY < 1) ? 1 : $clog2(MAX_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MAX_LATENCY);
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FIRST = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        max_a_q, max_a_d;
  logic [31:0]        max_b_q, max_b_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               hs;
  logic               lat_done;

  assign in_ready  = (state_q == S_FIRST) || (state_q == S_FETCH);
  assign hs        = in_valid && in_ready;
  assign lat_done  = (state_q == S_WAIT) && (lat_q == LAT_LAST);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = acc_q;
  assign max_a     = max_a_q;
  assign max_b     = max_b_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    max_a_d = max_a_q;
    max_b_d = max_b_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d = len;
          if (len == '0) begin
            acc_d   = NEG_INF;
            state_d = S_DONE;
          end else begin
            state_d = S_FIRST;
          end
        end
      end
      S_FIRST: begin
        // The first element seeds the accumulator directly; no compare is needed.
        if (hs) begin
          acc_d   = in_data;
          rem_d   = rem_q - COUNT_W'(1);
          state_d = (rem_q == COUNT_W'(1)) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (hs) begin
          max_a_d = acc_q;
          max_b_d = in_data;
          rem_d   = rem_q - COUNT_W'(1);
          lat_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Operands appear in the first WAIT cycle; max_z is valid MAX_LATENCY cycles later.
        if (lat_done) begin
          acc_d   = max_z;
          state_d = (rem_q == '0) ? S_DONE : S_FETCH;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      acc_q   <= '0;
      max_a_q <= '0;
      max_b_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      max_a_q <= max_a_d;
      max_b_q <= max_b_d;
      lat_q   <= lat_d;
    end
  end

`ifdef SINGLE_MAX_REDUCE_INDEX_EN
  logic [COUNT_W-1:0] elem_q, elem_d;
  logic [COUNT_W-1:0] cur_q, cur_d;
  logic [COUNT_W-1:0] idx_q, idx_d;

  // Only a strict win by the new element moves the index, so ties keep the earliest one.
  always_comb begin
    elem_d = elem_q;
    cur_d  = cur_q;
    idx_d  = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          elem_d = '0;
          idx_d  = '0;
        end
      end
      S_FIRST: if (hs) elem_d = elem_q + COUNT_W'(1);
      S_FETCH: begin
        if (hs) begin
          cur_d  = elem_q;
          elem_d = elem_q + COUNT_W'(1);
        end
      end
      S_WAIT: begin
        if (lat_done && (max_z == max_b_q) && (max_z != max_a_q)) idx_d = cur_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elem_q <= '0;
      cur_q  <= '0;
      idx_q  <= '0;
    end else begin
      elem_q <= elem_d;
      cur_q  <= cur_d;
      idx_q  <= idx_d;
    end
  end

  assign out_index = idx_q;
`endif

endmodule

// File: tb/tb_single_max_reduce.sv
// Directed bench for single_max_reduce with a float-max reference model and scoreboard.
module tb_single_max_reduce;
  localparam int L  = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, out_valid, out_ready, busy;
  logic [CW-1:0] len;
  logic [31:0]   in_data, out_data, max_a, max_b, max_z;
`ifdef SINGLE_MAX_REDUCE_INDEX_EN
  logic [CW-1:0] out_index;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_wait;
  bit in_ready_seen;
  int hs_log[$];
  logic [31:0]   vec[$];
  logic [31:0]   exp_d_q[$];
  logic [CW-1:0] exp_i_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  single_max_reduce #(.MAX_LATENCY(L), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .max_a(max_a), .max_b(max_b), .max_z(max_z)
`ifdef SINGLE_MAX_REDUCE_INDEX_EN
    , .out_index(out_index)
`endif
  );

  // Ordering key for non-NaN IEEE-754 singles: larger key means larger value.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    return (fkey(b) > fkey(a)) ? b : a;
  endfunction

  // External single_max stand-in with latency L.
  logic [31:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= fmax(max_a, max_b);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign max_z = pipe[L-1];

  task automatic ref_reduce(output logic [31:0] d, output logic [CW-1:0] idx);
    logic [31:0] z;
    d = 32'hFF80_0000;
    idx = '0;
    for (int i = 0; i < vec.size(); i++) begin
      if (i == 0) d = vec[0];
      else begin
        z = fmax(d, vec[i]);
        if (z == vec[i] && z != d) idx = CW'(i);
        d = z;
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (in_ready) in_ready_seen = 1'b1;
    if (!rst && out_valid) begin
      if (exp_d_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got %08h expected none", out_data);
      end else begin
        check("out_data", out_data, exp_d_q[0]);
`ifdef SINGLE_MAX_REDUCE_INDEX_EN
        check("out_index", 32'(out_index), 32'(exp_i_q[0]));
`endif
        if (out_ready) begin
          void'(exp_d_q.pop_front());
          void'(exp_i_q.pop_front());
        end
      end
    end
  end

  // Runs one reduction over vec; abort>0 stops after that many handshakes without expecting a result.
  task automatic run_vec(input string nm, input logic [31:0] lit_d, input logic [CW-1:0] lit_i,
                         input bit gaps, input bit poke, input int abort);
    logic [31:0] d;
    logic [CW-1:0] idx;
    int k, c;
    bit hs;
    ref_reduce(d, idx);
    check({nm, "_model_data"}, d, lit_d);
    check({nm, "_model_index"}, 32'(idx), 32'(lit_i));
    if (abort == 0) begin
      exp_d_q.push_back(d);
      exp_i_q.push_back(idx);
    end
    hs_log.delete();
    start = 1'b1;
    len = CW'(vec.size());
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    c = 0;
    while (k < vec.size() && c < 200 && !(abort > 0 && k >= abort)) begin
      in_data  = vec[k];
      in_valid = gaps ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      start    = poke;
      len      = '0;
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        hs_log.push_back(cyc);
        k++;
      end
      c++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (c >= 200) check({nm, "_feed_timeout"}, 32'(k), 32'(vec.size()));
    if (abort > 0) return;
    done_wait = 0;
    while (!out_valid && done_wait < 200) begin
      @(posedge clk); #1;
      done_wait++;
    end
    if (done_wait >= 200) check({nm, "_done_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic finish_ok(input string nm);
    @(posedge clk); #1;
    check({nm, "_idle_busy"}, 32'(busy), 32'd0);
    check({nm, "_idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] sa, sb, d0;
    rst = 1'b1; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_max_a", max_a, 32'd0);
    check("rst_max_b", max_b, 32'd0);
    rst = 1'b0;
    in_data = 32'h1234_5678;
    in_valid = 1'b1;
    in_ready_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_pending_no_ready", 32'(in_ready_seen), 32'd0);
    in_valid = 1'b0;

    // Gap-free length-4 vector; also checks element spacing.
    vec.delete();
    vec.push_back(32'h3F80_0000); vec.push_back(32'hC040_0000);
    vec.push_back(32'h4000_0000); vec.push_back(32'h3F00_0000);
    run_vec("len4", 32'h4000_0000, CW'(2), 1'b0, 1'b0, 0);
    check("len4_first_gap", 32'(hs_log[1] - hs_log[0]), 32'd1);
    check("len4_spacing_a", 32'(hs_log[2] - hs_log[1]), 32'(L + 2));
    check("len4_spacing_b", 32'(hs_log[3] - hs_log[2]), 32'(L + 2));
    finish_ok("len4");

    // Same vector with a bubbly in_valid.
    run_vec("len4_gaps", 32'h4000_0000, CW'(2), 1'b1, 1'b0, 0);
    check("gaps_hs_count", 32'(hs_log.size()), 32'd4);
    finish_ok("len4_gaps");

    // Empty vector.
    sa = max_a; sb = max_b;
    vec.delete();
    in_ready_seen = 1'b0;
    run_vec("len0", 32'hFF80_0000, CW'(0), 1'b0, 1'b0, 0);
    check("len0_latency", 32'(done_wait), 32'd0);
    check("len0_no_ready", 32'(in_ready_seen), 32'd0);
    check("len0_max_a", max_a, sa);
    check("len0_max_b", max_b, sb);
    finish_ok("len0");

    // Single element with start poked while busy.
    sa = max_a; sb = max_b;
    vec.delete();
    vec.push_back(32'hC040_0000);
    run_vec("len1", 32'hC040_0000, CW'(0), 1'b0, 1'b1, 0);
    start = 1'b1;
    check("len1_max_a", max_a, sa);
    check("len1_max_b", max_b, sb);
    finish_ok("len1");
    start = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Tie plus output backpressure.
    vec.delete();
    vec.push_back(32'h4000_0000); vec.push_back(32'h4000_0000);
    out_ready = 1'b0;
    run_vec("len2_tie", 32'h4000_0000, CW'(0), 1'b0, 1'b0, 0);
    d0 = out_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_data", out_data, d0);
    end
    out_ready = 1'b1;
    finish_ok("len2_tie");

    // Reset while waiting on single_max.
    vec.delete();
    vec.push_back(32'h4100_0000); vec.push_back(32'h4200_0000);
    vec.push_back(32'h4300_0000); vec.push_back(32'h4400_0000);
    run_vec("abort", 32'h4400_0000, CW'(3), 1'b0, 1'b0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data", out_data, 32'd0);
    check("abort_max_b", max_b, 32'd0);
    vec.delete();
    vec.push_back(32'h3F00_0000); vec.push_back(32'h3F80_0000);
    run_vec("after_abort", 32'h3F80_0000, CW'(1), 1'b0, 1'b0, 0);
    finish_ok("after_abort");

    check("scoreboard_empty", 32'(exp_d_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/single_max_reduce.md
Name: single_max_reduce

Overview:
Sequencer that computes the maximum of a vector of IEEE-754 single-precision values by time-sharing one external pipelined single_max unit. It accepts a length and a start pulse, pulls elements through a valid/ready stream, and issues (running max, element) pairs to the single_max unit. It waits a fixed pipeline latency for each result, then returns the final maximum on a valid/ready output. It sits between a vector source (DMA/stim reader) and result consumers.

Parameters:
MAX_LATENCY, 2, cycles from operands presented on max_a/max_b to the corresponding valid max_z (>=1)
COUNT_W, 16, width of the length and element counters

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin a reduction; honoured only in IDLE
len  in  COUNT_W  vector length, sampled on an accepted start
in_data  in  32  element, IEEE-754 single
in_valid  in  1  element valid
in_ready  out  1  element accepted when in_valid && in_ready
out_data  out  32  reduction result
out_valid  out  1  result valid, held until out_ready
out_ready  in  1  consumer accepts result
busy  out  1  high in every state except IDLE
max_a  out  32  operand A to single_max (running max)
max_b  out  32  operand B to single_max (new element)
max_z  in  32  result from single_max

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset: state=IDLE; in_ready=0, out_valid=0, busy=0, out_data=0, max_a=0, max_b=0, counters=0. Reset mid-operation aborts immediately and drops the partial result. The single_max pipeline is not flushed; its in-flight results are ignored.
- States: IDLE, FIRST, FETCH, WAIT, DONE.
- IDLE: start=1 latches len into remaining counter.
  - len=0 -> DONE with acc=32'hFF800000 (-inf).
  - otherwise -> FIRST.
  - start in any other state is ignored.
- FIRST: in_ready=1. On handshake: acc<=in_data, remaining-=1. If remaining becomes 0 -> DONE, else -> FETCH. No max operation is issued for the first element.
- FETCH: in_ready=1. On handshake: max_a<=acc, max_b<=in_data, remaining-=1, latency counter<=0, -> WAIT.
- WAIT: in_ready=0. max_a/max_b are held stable. Operands are first presented in cycle T; the controller captures max_z into acc at the end of cycle T+MAX_LATENCY. It then goes to DONE if remaining=0, else to FETCH.
- Throughput: one element per MAX_LATENCY+2 cycles when in_valid stays high.
- DONE: out_valid=1, out_data=acc. Both are held unchanged until out_ready=1, then -> IDLE with out_valid=0 the next cycle.
- in_data is never accepted outside FIRST/FETCH. Data presented while IDLE stays pending (in_ready=0).
- The controller does no float compare itself; NaN and ±0 semantics are entirely those of single_max.
- len is an unsigned count of up to 2^COUNT_W-1 elements; the counter does not wrap.

Optional Feature:
SINGLE_MAX_REDUCE_INDEX_EN
- Defined: adds output out_index [COUNT_W-1:0], valid with out_data.
  - Index of the first element is 0.
  - On capture, out_index updates to the current element's index only if max_z == max_b and max_z != max_a (bitwise). Ties therefore keep the earliest index.
  - len=0 gives out_index=0.
  - Reset value is 0.
- Undefined: no out_index port, no index counter; all other behaviour is identical.

Test Plan:
- len=4, elements 3F800000, C0400000, 40000000, 3F000000, in_valid always 1, MAX_LATENCY=2 -> out_data=40000000, out_index=2. Element handshakes are spaced 4 cycles apart after the first.
- start with len=0 -> DONE the next cycle with out_data=FF800000, in_ready never asserted, max_a/max_b unchanged.
- len=1, element C0400000 -> out_data=C0400000, no change on max_a/max_b; start pulses while busy are ignored.
- len=2, elements 40000000, 40000000 -> out_data=40000000, out_index=0. Hold out_ready=0 for 5 cycles: out_valid and out_data stay stable, then one handshake returns to IDLE.
- in_valid toggling 1-0-0-1 during FETCH -> elements accepted only on handshake cycles; result unchanged versus the gap-free run.
- rst=1 in WAIT mid-vector -> next cycle IDLE, busy=0, out_valid=0. A new start with len=2 (3F000000, 3F800000) gives out_data=3F800000 unaffected by stale max_z.
